gs_core: RTL and testbench

//  One row-update of a Gauss-Seidel solver: x_next = (b - sum_k a_k*x_k) * a_down,

---
 rtl/gs_core.sv | 185 ++++++++++++++++++
 tb/tb_gs_core.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/gs_core.sv
// gs_core: one Gauss-Seidel row update, x_next = (b - sum a_k*x_k) * a_down.
// Four register stages: products, residual, scaled residual, saturated result.
// One row may enter every cycle. There is no back-pressure.

// Per-term multiplier lane: registers a_k * x_k as a full-width signed product.
module gs_mul_lane #(
    parameter int A_W = 8,
    parameter int X_W = 32,
    parameter int P_W = A_W + X_W
) (
    input  logic           i_clk,
    input  logic           i_reset,
    input  logic [A_W-1:0] a_i,
    input  logic [X_W-1:0] x_i,
    output logic [P_W-1:0] p_o
);

    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] x_ext;
    logic signed [P_W-1:0] p_d;
    logic        [P_W-1:0] p_q;

    // Sign-extend both operands to the product width so the multiply is exact.
    always_comb begin
        a_ext = $signed({{(P_W-A_W){a_i[A_W-1]}}, a_i});
        x_ext = $signed({{(P_W-X_W){x_i[X_W-1]}}, x_i});
        p_d   = a_ext * x_ext;
    end

    // The product register advances every cycle. Validity is tracked at the top level.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) p_q <= '0;
        else          p_q <= p_d;
    end

    assign p_o = p_q;

endmodule

module gs_core #(
    parameter int N_TERMS = 7,
    parameter int A_W     = 8,
    parameter int X_W     = 32,
    parameter int B_W     = 8,
    parameter int D_W     = 32,
    parameter int FRAC    = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [N_TERMS*A_W-1:0] a,
    input  logic [B_W-1:0]         b,
    input  logic [D_W-1:0]         a_down,
    input  logic                   i_valid,
    input  logic [N_TERMS*X_W-1:0] x,
    output logic                   o_valid,
    output logic [X_W-1:0]         x_next
);

    // Widths follow the arithmetic exactly, so no stage can overflow before saturation.
    localparam int LATENCY = 3;                       // valid shift-register depth
    localparam int P_W     = A_W + X_W;               // single product
    localparam int S_W     = P_W + $clog2(N_TERMS);   // sum of products
    localparam int R_W     = S_W + 1;                 // residual b<<FRAC - sum
    localparam int M_W     = R_W + D_W + 1;           // residual * {0,a_down}
    localparam int Q_W     = M_W - D_W;               // after dropping Q0.32 fraction

    // ---------------- stage 1: products ----------------
    logic [N_TERMS-1:0][P_W-1:0] prod;
    logic [B_W-1:0]              b_q1;
    logic [D_W-1:0]              adown_q1;

    for (genvar k = 0; k < N_TERMS; k++) begin : g_lane
        gs_mul_lane #(
            .A_W (A_W),
            .X_W (X_W),
            .P_W (P_W)
        ) u_lane (
            .i_clk   (i_clk),
            .i_reset (i_reset),
            .a_i     (a[k*A_W +: A_W]),
            .x_i     (x[k*X_W +: X_W]),
            .p_o     (prod[k])
        );
    end

    // Carry the side operands alongside the products.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            b_q1     <= '0;
            adown_q1 <= '0;
        end else begin
            b_q1     <= b;
            adown_q1 <= a_down;
        end
    end

    // ---------------- stage 2: residual ----------------
    logic signed [S_W-1:0] sum_d;
    logic signed [R_W-1:0] r_d;
    logic        [R_W-1:0] r_q;
    logic        [D_W-1:0] adown_q2;

    // Sum the sign-extended products. Then subtract the sum from b, aligned to Q16.16.
    always_comb begin
        sum_d = '0;
        for (int k = 0; k < N_TERMS; k++) begin
            sum_d = sum_d + $signed({{(S_W-P_W){prod[k][P_W-1]}}, prod[k]});
        end
        r_d = $signed({{(R_W-B_W-FRAC){b_q1[B_W-1]}}, b_q1, {FRAC{1'b0}}})
            - $signed({sum_d[S_W-1], sum_d});
    end

    // Register the residual and the reciprocal that it will be scaled by.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_q      <= '0;
            adown_q2 <= '0;
        end else begin
            r_q      <= r_d;
            adown_q2 <= adown_q1;
        end
    end

    // ---------------- stage 3: scale by reciprocal ----------------
    logic signed [M_W-1:0] r_ext;
    logic signed [M_W-1:0] d_ext;
    logic signed [M_W-1:0] m_d;
    logic        [Q_W-1:0] q_q;
    logic                  unused_m_lo;

    // a_down is unsigned Q0.32. A zero MSB keeps it positive in the signed multiply.
    always_comb begin
        r_ext = $signed({{(M_W-R_W){r_q[R_W-1]}}, r_q});
        d_ext = $signed({{(M_W-D_W){1'b0}}, adown_q2});
        m_d   = r_ext * d_ext;
    end

    // The fraction bits are dropped. Truncating a two's-complement value rounds toward -inf.
    assign unused_m_lo = ^m_d[D_W-1:0];

    // Keep the integer part of the scaled residual. This is equivalent to m >>> 32.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) q_q <= '0;
        else          q_q <= m_d[M_W-1:D_W];
    end

    // ---------------- stage 4: saturate and present ----------------
    logic [X_W-1:0] sat_d;
    logic           fits;

    // The value fits in 32 bits only when every bit above bit 30 equals the sign.
    always_comb begin
        fits  = (&q_q[Q_W-1:X_W-1]) | ~(|q_q[Q_W-1:X_W-1]);
        sat_d = q_q[X_W-1:0];
        if (!fits) begin
            sat_d = q_q[Q_W-1] ? {1'b1, {(X_W-1){1'b0}}} : {1'b0, {(X_W-1){1'b1}}};
        end
    end

    // ---------------- valid tracking ----------------
    logic [LATENCY-1:0] vld_pipe_q;
    logic               o_valid_q;
    logic [X_W-1:0]     x_next_q;

    // Shift the valid bits in step with the data stages.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            vld_pipe_q <= '0;
            o_valid_q  <= 1'b0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[LATENCY-2:0], i_valid};
            o_valid_q  <= vld_pipe_q[LATENCY-1];
        end
    end

    // The output loads only for a valid row. Otherwise it holds the last result.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset)                     x_next_q <= '0;
        else if (vld_pipe_q[LATENCY-1])   x_next_q <= sat_d;
    end

    assign o_valid = o_valid_q;
    assign x_next  = x_next_q;

endmodule

// File: tb/tb_gs_core.sv
// tb_gs_core: directed and random rows checked against an arithmetic reference model.
module tb_gs_core;

    logic         i_clk   = 1'b0;
    logic         i_reset = 1'b0;
    logic [55:0]  a       = '0;
    logic [7:0]   b       = '0;
    logic [31:0]  a_down  = '0;
    logic         i_valid = 1'b0;
    logic [223:0] x       = '0;
    logic         o_valid;
    logic [31:0]  x_next;

    always #5 i_clk = ~i_clk;

    gs_core dut (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .a       (a),
        .b       (b),
        .a_down  (a_down),
        .i_valid (i_valid),
        .x       (x),
        .o_valid (o_valid),
        .x_next  (x_next)
    );

    typedef struct {
        int          due;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_chk  = 0;
    int          n_err  = 0;
    int          edge_n = 0;
    logic [31:0] last_x = '0;
    logic [31:0] cur_exp = '0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    // Reference: plain wide arithmetic, floor division by 2^32, then clamp.
    function automatic logic [31:0] ref_row(input logic [55:0] av, input logic [7:0] bv,
                                            input logic [31:0] adv, input logic [223:0] xv);
        logic signed [127:0] s, r, m, q;
        s = '0;
        for (int k = 0; k < 7; k++)
            s = s + 128'($signed(av[8*k +: 8])) * 128'($signed(xv[32*k +: 32]));
        r = 128'($signed(bv)) * 128'sd65536 - s;
        m = r * 128'($signed({1'b0, adv}));
        q = m >>> 32;
        if (q > 128'sd2147483647)        return 32'h7FFFFFFF;
        else if (q < -128'sd2147483648)  return 32'h80000000;
        else                             return q[31:0];
    endfunction

    // Advance one edge. Record any row sampled there. Then check the outputs just after the edge.
    task automatic tick();
        @(posedge i_clk);
        edge_n++;
        if (i_valid && i_reset) sb.push_back('{edge_n + 3, cur_exp});
        #1;
        if (sb.size() > 0 && sb[0].due == edge_n) begin
            chk("o_valid", 64'(o_valid), 64'd1);
            chk("x_next", 64'(x_next), 64'(sb[0].val));
            last_x = sb[0].val;
            sb.delete(0);
        end else begin
            chk("o_valid_idle", 64'(o_valid), 64'd0);
            chk("x_hold", 64'(x_next), 64'(last_x));
        end
    endtask

    task automatic drive(input logic v, input logic [55:0] av, input logic [7:0] bv,
                         input logic [31:0] adv, input logic [223:0] xv, input logic [31:0] ev);
        i_valid = v; a = av; b = bv; a_down = adv; x = xv; cur_exp = ev;
    endtask

    task automatic idle(input int n);
        drive(1'b0, '0, '0, '0, '0, '0);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rand_row();
        logic [55:0]  av;
        logic [223:0] xv;
        logic [7:0]   bv;
        logic [31:0]  adv;
        logic         v;
        int           sel;
        v = ($urandom_range(3) != 0);
        for (int k = 0; k < 7; k++) av[8*k +: 8] = 8'($urandom);
        for (int k = 0; k < 7; k++)
            xv[32*k +: 32] = ($urandom_range(1) == 0) ? 32'($urandom)
                                                      : 32'($urandom_range(262143)) - 32'd131072;
        bv  = 8'($urandom);
        sel = int'($urandom_range(5));
        case (sel)
            0:       adv = 32'h0;
            1:       adv = 32'hFFFFFFFF;
            2:       adv = 32'h40000000;
            default: adv = $urandom;
        endcase
        drive(v, av, bv, adv, xv, ref_row(av, bv, adv, xv));
    endtask

    initial begin
        // The outputs clear at once while reset is asserted.
        #1;
        chk("rst_ov", 64'(o_valid), 64'd0);
        chk("rst_x", 64'(x_next), 64'd0);
        tick();
        tick();
        i_reset = 1'b1;

        // Directed rows, run back to back. The first three also cover in-order streaming.
        drive(1'b1, 56'h0, 8'd3, 32'h40000000, {7{32'h12345678}}, 32'h0000C000);
        tick();
        drive(1'b1, 56'h01, 8'd5, 32'h40000000, 224'h10000, 32'h00010000);
        tick();
        drive(1'b1, 56'hFE, 8'h00, 32'h40000000, 224'h10000, 32'h00008000);
        tick();
        drive(1'b1, 56'h0, 8'hFF, 32'h55555555, 224'h0, 32'hFFFFAAAA);
        tick();
        drive(1'b1, 56'h80, 8'd127, 32'hFFFFFFFF, 224'h7FFFFFFF, 32'h7FFFFFFF);
        tick();
        drive(1'b1, 56'h01, 8'd5, 32'h0, 224'h10000, 32'h0);
        tick();
        idle(5);

        // Random traffic with gaps.
        for (int i = 0; i < 300; i++) begin
            rand_row();
            tick();
        end

        // Assert reset mid-stream, between edges.
        #2;
        i_reset = 1'b0;
        #1;
        chk("mid_rst_ov", 64'(o_valid), 64'd0);
        chk("mid_rst_x", 64'(x_next), 64'd0);
        sb.delete();
        last_x = '0;
        tick();
        tick();
        i_reset = 1'b1;
        for (int i = 0; i < 100; i++) begin
            rand_row();
            tick();
        end
        idle(6);
        chk("drain", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
